// File: rtl/ads127l01_fsync_rx.sv
// ADS127L01 frame-sync master-mode receiver: synchronises sck/dout/fsync, shifts 24-bit frames
// and presents sign-extended samples on a one-entry valid/ready stream. Optional macro: LPDAQ_RX_FRAME_ERR_EN.
module ads127l01_fsync_rx #(
    parameter int DATA_W      = 24,
    parameter int OUT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 sck,
    input  logic                 dout,
    input  logic                 fsync,
    output logic [OUT_W-1:0]     m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 busy,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] frame_err_cnt
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] dout_sync_q, dout_sync_d;
    logic [SYNC_STAGES-1:0] fs_sync_q, fs_sync_d;
    logic                   sck_dly_q, sck_dly_d, fs_dly_q, fs_dly_d, dout_dly_q, dout_dly_d;
    logic                   sck_rise_q, sck_rise_d, fs_rise_q, fs_rise_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [OUT_W-1:0]       tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   overrun_q, overrun_d;

    function automatic logic [OUT_W-1:0] sign_extend(input logic signed [DATA_W-1:0] x);
        return {{(OUT_W-DATA_W){x[DATA_W-1]}}, x};
    endfunction

`ifdef LPDAQ_RX_FRAME_ERR_EN
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        dout_sync_d = {dout_sync_q[SYNC_STAGES-2:0], dout};
        fs_sync_d   = {fs_sync_q[SYNC_STAGES-2:0], fsync};
        sck_dly_d   = sck_sync_q[SYNC_STAGES-1];
        fs_dly_d    = fs_sync_q[SYNC_STAGES-1];
        // dout takes the same extra stage as the rise detects so a shift sees the bit sampled with its edge
        dout_dly_d  = dout_sync_q[SYNC_STAGES-1];
        sck_rise_d  = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
        fs_rise_d   = fs_sync_q[SYNC_STAGES-1] & ~fs_dly_q;

        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q & ~clr;
`ifdef LPDAQ_RX_FRAME_ERR_EN
        frame_err = 1'b0;
`endif
        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fs_rise_q && en) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    shreg_d  = '0;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_d = IDLE;
`ifdef LPDAQ_RX_FRAME_ERR_EN
                end else if (fs_rise_q) begin
                    // A new frame start mid-frame aborts the current one and restarts shifting.
                    frame_err = 1'b1;
                    bitcnt_d  = '0;
                    shreg_d   = '0;
`endif
                end else if (sck_rise_q) begin
                    shreg_d  = {shreg_q[DATA_W-2:0], dout_dly_q};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (en) begin
                    if (!tvalid_q || m_tready) begin
                        tdata_d  = sign_extend(shreg_q);
                        tvalid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sck_sync_q  <= '0;
            dout_sync_q <= '0;
            fs_sync_q   <= '0;
            sck_dly_q   <= 1'b0;
            fs_dly_q    <= 1'b0;
            dout_dly_q  <= 1'b0;
            sck_rise_q  <= 1'b0;
            fs_rise_q   <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            dout_sync_q <= dout_sync_d;
            fs_sync_q   <= fs_sync_d;
            sck_dly_q   <= sck_dly_d;
            fs_dly_q    <= fs_dly_d;
            dout_dly_q  <= dout_dly_d;
            sck_rise_q  <= sck_rise_d;
            fs_rise_q   <= fs_rise_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef LPDAQ_RX_FRAME_ERR_EN
    // A clear coinciding with a new error still leaves that error counted.
    always_comb begin
        err_cnt_d = clr ? '0 : err_cnt_q;
        if (frame_err && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign frame_err_cnt = err_cnt_q;
`else
    assign frame_err_cnt = '0;
`endif

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/ads127l01_fsync_rx.md
# ads127l01_fsync_rx

Frame-sync serial receiver for the ADS127L01 running in frame-sync master mode: the ADC drives `sck`, `dout` and `fsync`, and this block deserialises each 24-bit two's-complement conversion. It sign-extends each sample to 32 bits and presents it on a valid/ready stream. It sits between the ADC pins and the sample FIFO that the PS drains through the data AXI window. Overrun and framing-error status are exported for the GPIO status registers.

## Interface
Parameters:
- `DATA_W`, 24: bits per ADC frame, MSB first.
- `OUT_W`, 32: output word width; the sample is sign-extended from `DATA_W`.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous pin input; minimum 2.
- `ERR_CNT_W`, 16: width of the framing-error counter.

Ports:
- `aclk` in 1: system clock, 100 MHz nominal.
- `areset` in 1: asynchronous, active-high reset.
- `en` in 1: receive enable, driven by the ADC-enable GPIO.
- `clr` in 1: single-cycle pulse that clears `overrun` and `frame_err_cnt`.
- `sck` in 1: ADC bit clock; asynchronous to `aclk`.
- `dout` in 1: ADC serial data; valid at `sck` rising edge.
- `fsync` in 1: ADC frame sync; a rising edge marks the frame start.
- `m_tdata` out `OUT_W`: sign-extended sample.
- `m_tvalid` out 1: `m_tdata` holds an unconsumed sample.
- `m_tready` in 1: downstream accepts the sample.
- `busy` out 1: a frame is being shifted in.
- `overrun` out 1: sticky; a completed frame was dropped.
- `frame_err_cnt` out `ERR_CNT_W`: saturating count of aborted frames.

## Operation
- `sck`, `dout` and `fsync` each pass through `SYNC_STAGES` flip-flops. One further register stage on each yields the rise detects `sck_rise` and `fs_rise`. `dout` is delayed by the same amount, so it stays aligned with `sck_rise`.
- States:
  - IDLE: leave on `fs_rise && en`, going to SHIFT with `bitcnt=0`.
  - SHIFT: on each `sck_rise`, shift `dout` into `shreg` (LSB in) and increment `bitcnt`.
    - When `bitcnt` reaches `DATA_W`, go to DONE.
    - An `fs_rise` while `bitcnt<DATA_W` is a framing error: `frame_err_cnt` increments, saturating at all-ones; `shreg` and `bitcnt` clear; the block stays in SHIFT, since this edge is a new frame start.
  - DONE, one cycle: load the output register, then go to IDLE.
- Output register, one entry:
  - Load is accepted if `!m_tvalid`, or if `m_tvalid && m_tready` in the same cycle (simultaneous consume and load).
  - Otherwise the new sample is discarded, the old sample is kept and `overrun` is set.
- Handshake: `m_tvalid` stays high until `m_tvalid && m_tready`. `m_tdata` is stable while `m_tvalid` is high.
- `en` low in SHIFT or DONE: the partial frame is dropped silently and the block goes to IDLE. There is no error and no `overrun`. The output register keeps its sample and remains drainable.
- `clr` in the same cycle as a new error or overrun: the new event wins, so the counter becomes 1 and `overrun` becomes 1.
- `busy` = (state != IDLE).

## Timing
- Reset values: `m_tdata`=0, `m_tvalid`=0, `busy`=0, `overrun`=0, `frame_err_cnt`=0, state IDLE, synchroniser flops 0.
- Input constraints: `sck` high and low each last at least 2 `aclk` periods, so the maximum `sck` is `aclk`/4. `dout` and `fsync` are stable for at least 1 `aclk` on each side of the `sck` rising edge.
- Latency: the 24th `sck` pin rising edge leads to `m_tvalid` high `SYNC_STAGES`+3 `aclk` later. That is 5 cycles at defaults: sync, edge detect, shift, DONE, register.
- Back-to-back frames: a new `fs_rise` can be accepted in the cycle after DONE.
- Asserting `areset` mid-frame clears everything immediately. The first frame after release starts at the next `fs_rise`.

## Configuration
- `LPDAQ_RX_FRAME_ERR_EN` defined: framing detection is active as described and `frame_err_cnt` counts.
- `LPDAQ_RX_FRAME_ERR_EN` undefined:
  - `fs_rise` in SHIFT is ignored; the frame completes on bit count alone.
  - `frame_err_cnt` is tied to 0 and its logic is removed.

## Test plan
- Reset, `en`=1, one frame of 24'h800001 with `sck`=`aclk`/8 and `m_tready`=1 -> one beat with `m_tdata`=32'hFF800001, exactly 5 cycles after the 24th `sck` rise.
- 100 frames of 24'h7FFFFF, 24'h000000 and random values back to back, `m_tready`=1 -> 100 beats in order, each sign-extended, `overrun`=0, `frame_err_cnt`=0.
- `m_tready`=0 across 3 frames (A, B, C) -> `m_tdata`=A held, `overrun`=1 after frame B. After `m_tready`=1, only A is delivered. Then pulse `clr` -> `overrun`=0.
- `fsync` re-asserted after 10 bits, followed by a full frame 24'h123456 -> `frame_err_cnt`=1 and one beat of 32'h00123456. With `LPDAQ_RX_FRAME_ERR_EN` undefined, `frame_err_cnt`=0.
- Deassert `en` after 12 bits, reassert it, send frame 24'hABCDEF -> no beat for the partial frame, then 32'hFFABCDEF, `frame_err_cnt`=0.
- Assert `areset` after 20 bits of a frame -> all outputs 0 immediately. The next full frame, 24'h000123, is received correctly.
